// File: rtl/mobo_mem_responder_pkg.sv
// rtl/mobo_mem_responder_pkg.sv - shared command/status encodings for the mobo handshake
package mobo_mem_responder_pkg;

  localparam int unsigned CTRL_NONE  = 0;
  localparam int unsigned CTRL_READ  = 1;
  localparam int unsigned CTRL_WRITE = 2;

  localparam int unsigned MOBO_IDLE = 0;
  localparam int unsigned MOBO_BUSY = 1;
  localparam int unsigned MOBO_DONE = 2;
  localparam int unsigned MOBO_ERR  = 3;

  // State codes equal the status codes so mobo_stat is the state register itself.
  typedef enum logic [1:0] {
    ST_IDLE = 2'(MOBO_IDLE),
    ST_BUSY = 2'(MOBO_BUSY),
    ST_DONE = 2'(MOBO_DONE),
    ST_ERR  = 2'(MOBO_ERR)
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mobo_ram.sv
// rtl/mobo_ram.sv - single-port word memory, synchronous write, combinational read
module mobo_ram
  import mobo_mem_responder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mobo_mem_responder.sv
// rtl/mobo_mem_responder.sv - board-side responder: command accept, wait states, DONE/ERR hold
module mobo_mem_responder
  import mobo_mem_responder_pkg::*;
#(
  parameter int word_width  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int DONE_HOLD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  output logic [word_width-1:0] mobo_stat,
  input  logic [word_width-1:0] cpu_addr,
  input  logic [word_width-1:0] cpu_wdata,
  output logic [word_width-1:0] cpu_rdata
);

  localparam int AW = addr_bits(DEPTH);
  localparam logic [word_width-1:0] C_NONE  = word_width'(CTRL_NONE);
  localparam logic [word_width-1:0] C_READ  = word_width'(CTRL_READ);
  localparam logic [word_width-1:0] C_WRITE = word_width'(CTRL_WRITE);
  localparam logic [word_width-1:0] DEPTH_W = word_width'(DEPTH);
  localparam logic [31:0] WAIT_INIT = 32'(WAIT_CYCLES);
  localparam logic [31:0] HOLD_INIT = 32'(DONE_HOLD - 1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  op_e                   last_q, last_d;
  logic                  armed_q, armed_d;
  logic [31:0]           wait_q, wait_d;
  logic [31:0]           hold_q, hold_d;
  logic [word_width-1:0] addr_q, addr_d;
  logic [word_width-1:0] wdata_q, wdata_d;
  logic [word_width-1:0] rdata_q, rdata_d;

  op_e                   cmd_op;
  logic                  cmd_illegal;
  logic                  accept;
  logic                  addr_ok;
  logic                  mem_we;
  logic [word_width-1:0] mem_rdata;

  always_comb begin
    cmd_op      = OP_NONE;
    cmd_illegal = 1'b0;
    if (mobo_ctrl == C_READ) begin
      cmd_op = OP_READ;
    end else if (mobo_ctrl == C_WRITE) begin
      cmd_op = OP_WRITE;
    end else if (mobo_ctrl != C_NONE) begin
      cmd_illegal = 1'b1;
    end
  end

  // A command equal to the last completed one is only re-run after an intervening NONE.
  assign accept  = (state_q == ST_IDLE) && (cmd_op != OP_NONE) && armed_q &&
                   ((cmd_op != last_q) || (last_q == OP_NONE));
  assign addr_ok = (addr_q < DEPTH_W);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    last_d  = last_q;
    armed_d = armed_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_illegal) begin
          state_d = ST_ERR;
          op_d    = OP_NONE;
          hold_d  = HOLD_INIT;
          armed_d = 1'b0;
        end else if (cmd_op == OP_NONE) begin
          last_d = OP_NONE;
        end else if (accept) begin
          state_d = ST_BUSY;
          op_d    = cmd_op;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wait_d  = WAIT_INIT;
          armed_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (wait_q != 32'd0) begin
          wait_d = wait_q - 32'd1;
        end else if (!addr_ok) begin
          state_d = ST_ERR;
          hold_d  = HOLD_INIT;
        end else begin
          state_d = ST_DONE;
          hold_d  = HOLD_INIT;
          mem_we  = (op_q == OP_WRITE);
          if (op_q == OP_READ) begin
            rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        if (hold_q != 32'd0) begin
          hold_d = hold_q - 32'd1;
        end else begin
          state_d = ST_IDLE;
          last_d  = op_q;
          armed_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      last_q  <= OP_NONE;
      armed_q <= 1'b1;
      wait_q  <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mobo_ram #(
    .WIDTH (word_width),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign mobo_stat = word_width'(state_q);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// tb/tb_mobo_mem_responder.sv - directed self-checking bench for mobo_mem_responder
module tb_mobo_mem_responder;
  import mobo_mem_responder_pkg::*;

  localparam logic [31:0] S_IDLE = 32'(MOBO_IDLE);
  localparam logic [31:0] S_BUSY = 32'(MOBO_BUSY);
  localparam logic [31:0] S_DONE = 32'(MOBO_DONE);
  localparam logic [31:0] S_ERR  = 32'(MOBO_ERR);
  localparam logic [31:0] C_NONE = 32'(CTRL_NONE);
  localparam logic [31:0] C_R    = 32'(CTRL_READ);
  localparam logic [31:0] C_W    = 32'(CTRL_WRITE);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, addr, wdata, stat, rdata;
  logic [31:0] ctrl0, addr0, wdata0, stat0, rdata0;
  logic [31:0] fin;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mobo_mem_responder #(.word_width(32), .DEPTH(256), .WAIT_CYCLES(2), .DONE_HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .mobo_ctrl(ctrl), .mobo_stat(stat),
    .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rdata)
  );

  mobo_mem_responder #(.word_width(32), .DEPTH(256), .WAIT_CYCLES(0), .DONE_HOLD(2)) u_dut0 (
    .clk(clk), .rst(rst), .mobo_ctrl(ctrl0), .mobo_stat(stat0),
    .cpu_addr(addr0), .cpu_wdata(wdata0), .cpu_rdata(rdata0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && stat != S_IDLE; i++) tick();
    check(tag, stat, S_IDLE);
  endtask

  task automatic do_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] result);
    ctrl = C_NONE;
    tick();
    ctrl = op; addr = a; wdata = d;
    tick();
    for (int i = 0; i < 20 && stat == S_BUSY; i++) tick();
    result = stat;
    wait_idle("op_idle");
  endtask

  initial begin
    rst = 1'b1;
    ctrl = C_NONE; addr = '0; wdata = '0;
    ctrl0 = C_NONE; addr0 = '0; wdata0 = '0;
    tick(); tick();
    check("rst_stat", stat, S_IDLE);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stat0", stat0, S_IDLE);
    rst = 1'b0;
    tick();

    // write 3 <- 5 with exact BUSY/DONE timing
    addr = 32'd3; wdata = 32'd5; ctrl = C_W;
    tick(); check("wr_busy1", stat, S_BUSY);
    tick(); check("wr_busy2", stat, S_BUSY);
    tick(); check("wr_busy3", stat, S_BUSY);
    tick(); check("wr_done1", stat, S_DONE);
    tick(); check("wr_done2", stat, S_DONE);
    tick(); check("wr_idle", stat, S_IDLE);

    wdata = 32'd6;
    for (int i = 0; i < 20; i++) begin
      tick(); check("held_idle", stat, S_IDLE);
    end

    ctrl = C_R; addr = 32'd3;
    tick(); check("rd_busy", stat, S_BUSY);
    tick(); tick();
    tick(); check("rd_done", stat, S_DONE);
    check("rd_data", rdata, 32'd5);

    // WRITE presented during DONE is taken on the first IDLE cycle
    ctrl = C_W; wdata = 32'd8;
    tick(); check("b2b_done2", stat, S_DONE);
    tick(); check("b2b_idle", stat, S_IDLE);
    tick(); check("b2b_accept", stat, S_BUSY);
    wait_idle("b2b_end");

    tick(); check("hold_again", stat, S_IDLE);
    ctrl = C_NONE;
    tick(); check("none_idle", stat, S_IDLE);
    ctrl = C_W; wdata = 32'd5;
    tick(); check("rearm_busy", stat, S_BUSY);
    wait_idle("rearm_end");

    do_op(C_R, 32'd3, 32'd0, fin);
    check("rearm_rd_stat", fin, S_DONE);
    check("rearm_rd_data", rdata, 32'd5);

    do_op(C_W, 32'd44, 32'h44, fin);
    check("wr44_stat", fin, S_DONE);

    ctrl = C_NONE;
    tick();
    addr = 32'd256; ctrl = C_R;
    tick(); check("oor_busy", stat, S_BUSY);
    tick(); tick();
    tick(); check("oor_err", stat, S_ERR);
    check("oor_rdata", rdata, 32'd5);
    tick(); check("oor_err2", stat, S_ERR);
    tick(); check("oor_idle", stat, S_IDLE);

    do_op(C_W, 32'd300, 32'hBAD, fin);
    check("oor_wr_err", fin, S_ERR);
    do_op(C_R, 32'd44, 32'd0, fin);
    check("mem44_data", rdata, 32'h44);

    // inputs changing while BUSY are ignored
    do_op(C_W, 32'd11, 32'h1111, fin);
    check("wr11_stat", fin, S_DONE);
    ctrl = C_NONE;
    tick();
    addr = 32'd10; wdata = 32'd1; ctrl = C_W;
    tick(); check("chg_busy", stat, S_BUSY);
    addr = 32'd11; wdata = 32'd2; ctrl = C_R;
    tick(); tick();
    tick(); check("chg_done", stat, S_DONE);
    tick(); check("chg_done2", stat, S_DONE);
    tick(); check("chg_idle", stat, S_IDLE);
    tick(); check("chg_rd_accept", stat, S_BUSY);
    tick(); tick();
    tick(); check("chg_rd_done", stat, S_DONE);
    check("chg_rd_data", rdata, 32'h1111);
    wait_idle("chg_end");
    do_op(C_R, 32'd10, 32'd0, fin);
    check("mem10_data", rdata, 32'd1);

    // zero wait states
    addr0 = 32'd0; wdata0 = 32'hDEADBEEF; ctrl0 = C_W;
    tick(); check("z_wr_busy", stat0, S_BUSY);
    tick(); check("z_wr_done", stat0, S_DONE);
    ctrl0 = C_R;
    tick(); check("z_done2", stat0, S_DONE);
    tick(); check("z_idle", stat0, S_IDLE);
    tick(); check("z_rd_busy", stat0, S_BUSY);
    tick(); check("z_rd_done", stat0, S_DONE);
    check("z_rd_data", rdata0, 32'hDEADBEEF);

    // asynchronous reset in the middle of a pending write
    do_op(C_W, 32'd7, 32'h77, fin);
    check("wr7_stat", fin, S_DONE);
    ctrl = C_NONE;
    tick();
    addr = 32'd7; wdata = 32'd9; ctrl = C_W;
    tick(); check("rst_mid_busy", stat, S_BUSY);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_stat", stat, S_IDLE);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_rdata0", rdata0, 32'd0);
    ctrl = C_NONE; ctrl0 = C_NONE;
    tick(); tick();
    rst = 1'b0;
    tick();
    do_op(C_R, 32'd7, 32'd0, fin);
    check("rst_rd7_stat", fin, S_DONE);
    check("rst_rd7_data", rdata, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
